// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit with HI/LO registers.
// Runs mult/multu/div/divu with fixed latencies and a registered busy flag.
// mthi/mtlo complete in a single cycle.
// Define MDU_MADD_EN to add madd/maddu/msub/msubu. These accumulate into
// {hi,lo} with the multiply latency.
module mult_div_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_MTHI  = 4'b0101;
    localparam logic [3:0] OP_MTLO  = 4'b0110;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'b0111;
    localparam logic [3:0] OP_MADDU = 4'b1000;
    localparam logic [3:0] OP_MSUB  = 4'b1001;
    localparam logic [3:0] OP_MSUBU = 4'b1010;
`endif

    logic [0:0]       state;
    logic [CW-1:0]    count;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic             launch_mul;
    logic             launch_div;

    logic             is_signed;
    logic             is_div;
`ifdef MDU_MADD_EN
    logic             is_acc;
    logic             is_sub;
`endif

    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] product;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH-1:0]   div_b;
    logic [WIDTH-1:0]   quot_u;
    logic [WIDTH-1:0]   rem_u;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [2*WIDTH-1:0] hilo_next;
    logic               write_en;

    // Classify the incoming op: multi-cycle multiply class or divide class
    always_comb begin
        launch_mul = 1'b0;
        launch_div = 1'b0;
        case (op)
            OP_MULT, OP_MULTU: launch_mul = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: launch_mul = 1'b1;
`endif
            OP_DIV, OP_DIVU:   launch_div = 1'b1;
            default: ;
        endcase
    end

    // Decode the latched op into datapath controls
    always_comb begin
        is_signed = 1'b0;
        is_div    = 1'b0;
`ifdef MDU_MADD_EN
        is_acc    = 1'b0;
        is_sub    = 1'b0;
`endif
        case (op_q)
            OP_MULT:  is_signed = 1'b1;
            OP_DIV: begin
                is_signed = 1'b1;
                is_div    = 1'b1;
            end
            OP_DIVU:  is_div = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD: begin
                is_signed = 1'b1;
                is_acc    = 1'b1;
            end
            OP_MADDU: is_acc = 1'b1;
            OP_MSUB: begin
                is_signed = 1'b1;
                is_acc    = 1'b1;
                is_sub    = 1'b1;
            end
            OP_MSUBU: begin
                is_acc = 1'b1;
                is_sub = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Result datapath from the latched operands.
    // A 2W-wide product of sign/zero-extended operands gives the signed or
    // unsigned result. Signed divide uses magnitude division with sign
    // fix-up, so MIN/-1 wraps to MIN with remainder 0.
    always_comb begin
        ext_a   = is_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        ext_b   = is_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        product = ext_a * ext_b;

        a_neg  = is_signed & a_q[WIDTH-1];
        b_neg  = is_signed & b_q[WIDTH-1];
        abs_a  = a_neg ? ('0 - a_q) : a_q;
        abs_b  = b_neg ? ('0 - b_q) : b_q;
        div_b  = (abs_b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : abs_b;
        quot_u = abs_a / div_b;
        rem_u  = abs_a % div_b;
        quot   = (a_neg ^ b_neg) ? ('0 - quot_u) : quot_u;
        rem    = a_neg ? ('0 - rem_u) : rem_u;

        hilo_next = product;
        write_en  = 1'b1;
        if (is_div) begin
            hilo_next = {rem, quot};
            write_en  = (b_q != '0);
        end
`ifdef MDU_MADD_EN
        else if (is_acc) begin
            hilo_next = is_sub ? ({hi, lo} - product) : ({hi, lo} + product);
        end
`endif
    end

    // Control FSM, latency counter, operand latches and HI/LO registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            count <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (launch_mul || launch_div) begin
                            op_q  <= op;
                            a_q   <= inA;
                            b_q   <= inB;
                            count <= launch_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                            busy  <= 1'b1;
                            state <= S_BUSY;
                        end else if (op == OP_MTHI) begin
                            hi <= inA;
                        end else if (op == OP_MTLO) begin
                            lo <= inA;
                        end
                    end
                end
                S_BUSY: begin
                    if (count == CW'(1)) begin
                        if (write_en) begin
                            hi <= hilo_next[2*WIDTH-1:WIDTH];
                            lo <= hilo_next[WIDTH-1:0];
                        end
                        busy  <= 1'b0;
                        count <= '0;
                        state <= S_IDLE;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed-vector bench for mult_div_unit.
// Expected values are hand-computed. Define MDU_MADD_EN to exercise the
// accumulate ops.
module tb_mult_div_unit;

    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_MTHI  = 4'b0101;
    localparam logic [3:0] OP_MTLO  = 4'b0110;
    localparam logic [3:0] OP_MADDU = 4'b1000;
    localparam logic [3:0] OP_MSUB  = 4'b1001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = '0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_pass   = 0;
    int cycles;

    mult_div_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .inA   (in_a),
        .inB   (in_b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    // Count one comparison and report it if the observed value differs
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Issue one op, then count the cycles busy stays high (bounded).
    // mode 1 changes the operand inputs mid-flight.
    // mode 2 pulses a start (mthi) while busy.
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int mode, output int n);
        @(negedge clk);
        start = 1'b1; op = o; in_a = a; in_b = b;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            n++;
            if (mode == 1 && n == 2) begin
                in_a = 32'h5A5A5A5A;
                in_b = 32'h00001234;
            end
            if (mode == 2 && n == 2) begin
                start = 1'b1; op = OP_MTHI; in_a = 32'hDEADBEEF;
            end
            if (mode == 2 && n == 3) start = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);

        // mult -1 * 2 = -2
        run_op(OP_MULT, 32'hFFFFFFFF, 32'd2, 0, cycles);
        check("mult_cycles", cycles, 32'd5);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFFE);

        // multu with inputs disturbed mid-flight
        run_op(OP_MULTU, 32'hFFFFFFFF, 32'd2, 1, cycles);
        check("multu_cycles", cycles, 32'd5);
        check("multu_hi", hi, 32'h00000001);
        check("multu_lo", lo, 32'hFFFFFFFE);

        // div -7 / 2 -> q=-3, r=-1
        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 0, cycles);
        check("div_cycles", cycles, 32'd10);
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);

        // divu by zero keeps hi/lo
        run_op(OP_DIVU, 32'd7, 32'd0, 0, cycles);
        check("div0_cycles", cycles, 32'd10);
        check("div0_lo", lo, 32'hFFFFFFFD);
        check("div0_hi", hi, 32'hFFFFFFFF);

        // mthi then mtlo on consecutive cycles
        @(negedge clk);
        start = 1'b1; op = OP_MTHI; in_a = 32'h12345678;
        @(negedge clk);
        check("mthi_hi", hi, 32'h12345678);
        check("mthi_lo", lo, 32'hFFFFFFFD);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        op = OP_MTLO; in_a = 32'h9ABCDEF0;
        @(negedge clk);
        start = 1'b0;
        check("mtlo_lo", lo, 32'h9ABCDEF0);
        check("mtlo_hi", hi, 32'h12345678);
        check("mtlo_busy", {31'd0, busy}, 32'd0);

        // signed MIN / -1
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0, cycles);
        check("min_lo", lo, 32'h80000000);
        check("min_hi", hi, 32'h00000000);

        // (2^31-1)^2 = 2^62 - 2^32 + 1
        run_op(OP_MULT, 32'h7FFFFFFF, 32'h7FFFFFFF, 0, cycles);
        check("maxsq_hi", hi, 32'h3FFFFFFF);
        check("maxsq_lo", lo, 32'h00000001);

        // 7 / -2 -> q=-3, r=1
        run_op(OP_DIV, 32'd7, 32'hFFFFFFFE, 0, cycles);
        check("divneg_lo", lo, 32'hFFFFFFFD);
        check("divneg_hi", hi, 32'h00000001);

        // divu 100/7 with a start (mthi) pulsed while busy
        run_op(OP_DIVU, 32'd100, 32'd7, 2, cycles);
        check("ignore_cycles", cycles, 32'd10);
        check("ignore_lo", lo, 32'd14);
        check("ignore_hi", hi, 32'd2);

        // reset on the 3rd busy cycle of a div aborts it
        @(negedge clk);
        start = 1'b1; op = OP_DIV; in_a = 32'd50; in_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        check("abort_busy1", {31'd0, busy}, 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        repeat (12) @(negedge clk);
        check("abort_late_busy", {31'd0, busy}, 32'd0);
        check("abort_late_hi", hi, 32'd0);
        check("abort_late_lo", lo, 32'd0);

        // unassigned op code is a no-op
        run_op(4'b1111, 32'd3, 32'd4, 0, cycles);
        check("nop_cycles", cycles, 32'd0);
        check("nop_hi", hi, 32'd0);
        check("nop_lo", lo, 32'd0);

        // maddu into {0, FFFFFFFF}
        run_op(OP_MTHI, 32'd0, 32'd0, 0, cycles);
        run_op(OP_MTLO, 32'hFFFFFFFF, 32'd0, 0, cycles);
        run_op(OP_MADDU, 32'd1, 32'd1, 0, cycles);
`ifdef MDU_MADD_EN
        check("maddu_cycles", cycles, 32'd5);
        check("maddu_hi", hi, 32'd1);
        check("maddu_lo", lo, 32'd0);
        run_op(OP_MSUB, 32'd1, 32'd1, 0, cycles);
        check("msub_cycles", cycles, 32'd5);
        check("msub_hi", hi, 32'd0);
        check("msub_lo", lo, 32'hFFFFFFFF);
`else
        check("maddu_cycles", cycles, 32'd0);
        check("maddu_hi", hi, 32'd0);
        check("maddu_lo", lo, 32'hFFFFFFFF);
        run_op(OP_MSUB, 32'd1, 32'd1, 0, cycles);
        check("msub_cycles", cycles, 32'd0);
        check("msub_hi", hi, 32'd0);
        check("msub_lo", lo, 32'hFFFFFFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
